rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares a single resource, selected through a 2-to-4 enable decoder, between requesters 0..3. It drives a 2-bit grant index plus a grant-valid enable, which feed the select/enable pins of the shared decoder, and also supplies the decoded one-hot grant directly. A hold counter bounds tenure so no requester can starve the others.

---
 rtl/rr_arbiter4.sv | 102 ++++++++++
 tb/tb_rr_arbiter4.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded tenure.
// Drives a registered grant index/enable pair for a shared 2-to-4 decoder plus the decoded one-hot grant.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic          done,
  output logic          gnt_v,
  output logic [1:0]    gnt_idx,
  output logic [3:0]    gnt,
  output logic [CW-1:0] hold
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic          gnt_v_q, gnt_v_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [1:0]    ptr_q, ptr_d;

  logic [1:0]    arb_ptr;
  logic [1:0]    winner;
  logic          rel;

  // Scan starts at arb_ptr, so the previous holder (at arb_ptr-1) is checked last.
  always_comb begin
    winner = arb_ptr;
    for (int unsigned i = 4; i > 0; i--) begin
      if (req[arb_ptr + 2'(i - 1)]) winner = arb_ptr + 2'(i - 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_v_d   = gnt_v_q;
    gnt_idx_d = gnt_idx_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    arb_ptr   = ptr_q;
    rel       = done | ~req[gnt_idx_q] | (hold_q == HOLD_LAST);

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = GRANT;
          gnt_v_d   = 1'b1;
          gnt_idx_d = winner;
          hold_d    = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          hold_d = hold_q + 1'b1;
        end else begin
          ptr_d   = gnt_idx_q + 2'd1;
          arb_ptr = gnt_idx_q + 2'd1;
          hold_d  = '0;
          if (|req) begin
            gnt_idx_d = winner;
          end else begin
            state_d = IDLE;
            gnt_v_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = gnt_v_d ? (4'b0001 << gnt_idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_v_q   <= 1'b0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      hold_q    <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_v_q   <= gnt_v_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt_v   = gnt_v_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt     = gnt_q;
  assign hold    = hold_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed vectors queue hand-computed expectations,
// a monitor compares them against the registered outputs after each rising edge.
module tb_rr_arbiter4;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic          done = 1'b0;
  logic          gnt_v;
  logic [1:0]    gnt_idx;
  logic [3:0]    gnt;
  logic [CW-1:0] hold;

  typedef struct packed {
    logic          v;
    logic [1:0]    idx;
    logic [3:0]    g;
    logic [CW-1:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx),
    .gnt     (gnt),
    .hold    (hold)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [1:0] idx, input int h);
    exp_t e;
    e.v   = v;
    e.idx = idx;
    e.g   = v ? (4'b0001 << idx) : 4'b0000;
    e.h   = CW'(h);
    return e;
  endfunction

  // Monitor: every registered output update is checked against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (gnt_v !== e.v || gnt_idx !== e.idx || gnt !== e.g || hold !== e.h) begin
          n_fail++;
          $display("FAIL grant@%0t: got v=%b idx=%0d gnt=%b hold=%0d, want v=%b idx=%0d gnt=%b hold=%0d",
                   $time, gnt_v, gnt_idx, gnt, hold, e.v, e.idx, e.g, e.h);
        end
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic d,
                      input logic ev, input logic [1:0] eidx, input int eh);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back(mk(ev, eidx, eh));
  endtask

  task automatic check_now(input string name, input logic ev, input logic [1:0] eidx, input int eh);
    exp_t e;
    e = mk(ev, eidx, eh);
    n_tests++;
    if (gnt_v !== e.v || gnt_idx !== e.idx || gnt !== e.g || hold !== e.h) begin
      n_fail++;
      $display("FAIL %s: got v=%b idx=%0d gnt=%b hold=%0d, want v=%b idx=%0d gnt=%b hold=%0d",
               name, gnt_v, gnt_idx, gnt, hold, e.v, e.idx, e.g, e.h);
    end
  endtask

  initial begin
    #2;
    check_now("reset_init", 1'b0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Build a grant on requester 2 up to hold=3, then reset asynchronously between edges.
    step(4'b0100, 1'b0, 1'b1, 2'd2, 0);
    step(4'b0100, 1'b0, 1'b1, 2'd2, 1);
    step(4'b0100, 1'b0, 1'b1, 2'd2, 2);
    step(4'b0100, 1'b0, 1'b1, 2'd2, 3);
    @(posedge clk);
    #3;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #1;
    check_now("async_reset", 1'b0, 2'd0, 0);
    @(posedge clk);
    #1;
    check_now("reset_held", 1'b0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(1'b0, 2'd0, 0));
    step(4'b1111, 1'b0, 1'b1, 2'd0, 0);

    // Fairness: all requesting, done every cycle.
    step(4'b1111, 1'b1, 1'b1, 2'd1, 0);
    step(4'b1111, 1'b1, 1'b1, 2'd2, 0);
    step(4'b1111, 1'b1, 1'b1, 2'd3, 0);
    step(4'b1111, 1'b1, 1'b1, 2'd0, 0);
    step(4'b1111, 1'b1, 1'b1, 2'd1, 0);

    // Rotation from ptr with req=1011 after holder 2 releases.
    step(4'b0100, 1'b1, 1'b1, 2'd2, 0);
    step(4'b1011, 1'b1, 1'b1, 2'd3, 0);
    step(4'b1011, 1'b1, 1'b1, 2'd0, 0);
    step(4'b1011, 1'b1, 1'b1, 2'd1, 0);

    // Request drop: grant lingers one cycle, then idle; new request granted next edge.
    step(4'b0010, 1'b0, 1'b1, 2'd1, 1);
    step(4'b0000, 1'b0, 1'b0, 2'd1, 0);
    step(4'b0001, 1'b0, 1'b1, 2'd0, 0);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 0);

    // Timeout: holder 2 counts 0..7, then is re-granted back-to-back.
    for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b1, 2'd2, i);
    step(4'b0100, 1'b0, 1'b1, 2'd2, 0);
    step(4'b0100, 1'b0, 1'b1, 2'd2, 1);

    // Wrap: holder 3 re-granted alone, then loses to requester 0.
    step(4'b1000, 1'b1, 1'b1, 2'd3, 0);
    step(4'b1000, 1'b1, 1'b1, 2'd3, 0);
    step(4'b1001, 1'b1, 1'b1, 2'd0, 0);

    // done while idle is ignored; non-holder changes don't disturb tenure.
    step(4'b0000, 1'b1, 1'b0, 2'd0, 0);
    step(4'b0000, 1'b1, 1'b0, 2'd0, 0);
    step(4'b0010, 1'b0, 1'b1, 2'd1, 0);
    step(4'b0111, 1'b0, 1'b1, 2'd1, 1);
    step(4'b1010, 1'b0, 1'b1, 2'd1, 2);
    step(4'b0000, 1'b0, 1'b0, 2'd1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
